// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 access encodings,
// controller state enum and the alignment/legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] MEM_F3_WORD = 3'b010;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } lsu_state_e;

    // Illegal funct3 for the direction, or an offset not aligned to the access size.
    function automatic logic lsu_access_err(input logic       we,
                                            input logic [2:0] f3,
                                            input logic [1:0] off);
        logic err;
        err = 1'b0;
        if (we) begin
            case (f3)
                F3_B:    err = 1'b0;
                F3_H:    err = off[0];
                F3_W:    err = |off;
                default: err = 1'b1;
            endcase
        end else begin
            case (f3)
                F3_B, F3_BU: err = 1'b0;
                F3_H, F3_HU: err = off[0];
                F3_W:        err = |off;
                default:     err = 1'b1;
            endcase
        end
        return err;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extracts and extends load lanes from a memory word and
// merges sub-word store data into a previously read word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_base,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_f3,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);

    logic [4:0]  w_shamt;
    logic [31:0] w_shifted;
    logic [31:0] w_mask;

    assign w_shamt   = {i_off, 3'b000};
    assign w_shifted = i_rdata >> w_shamt;

    // Load lane select with sign or zero extension.
    always_comb begin
        o_load_data = 32'd0;
        case (i_f3)
            F3_B:    o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_W:    o_load_data = w_shifted;
            F3_BU:   o_load_data = {24'd0, w_shifted[7:0]};
            F3_HU:   o_load_data = {16'd0, w_shifted[15:0]};
            default: o_load_data = 32'd0;
        endcase
    end

    // Store lane mask and merge of the shifted store data into the base word.
    always_comb begin
        w_mask = 32'hFFFF_FFFF;
        case (i_f3)
            F3_B:    w_mask = 32'h0000_00FF << w_shamt;
            F3_H:    w_mask = 32'h0000_FFFF << w_shamt;
            default: w_mask = 32'hFFFF_FFFF;
        endcase
        o_merge_data = (i_base & ~w_mask) | ((i_wdata << w_shamt) & w_mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: decodes core requests, performs
// sub-word stores as read-modify-write on a word-wide memory, returns responses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int P_ADDR_WIDTH = 11,
    parameter int P_DATA_WIDTH = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_we,
    input  logic [31:0]             i_req_addr,
    input  logic [2:0]              i_req_f3,
    input  logic [P_DATA_WIDTH-1:0] i_req_wdata,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [P_DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                    o_rsp_err,
    output logic                    o_mem_we,
    output logic [P_ADDR_WIDTH-1:0] o_mem_addr,
    output logic [2:0]              o_mem_f3,
    output logic [P_DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [P_DATA_WIDTH-1:0] i_mem_rdata
);

    lsu_state_e              r_state;
    lsu_state_e              w_next_state;
    logic                    r_req_ready;
    logic                    r_rsp_valid;
    logic                    r_rsp_err;
    logic                    r_mem_we;
    logic [31:0]             r_rsp_rdata;
    logic [31:0]             r_wdata;
    logic [31:0]             r_merge;
    logic [2:0]              r_f3;
    logic [1:0]              r_off;
    logic [P_ADDR_WIDTH-1:0] r_mem_addr;

    logic                    w_accept;
    logic                    w_range_err;
    logic                    w_err;
    logic [31:0]             w_load_data;
    logic [31:0]             w_merge_data;
    logic [31:0]             w_mem_wdata;

    // Ready is a registered copy of "in IDLE", so it also gates acceptance.
    assign w_accept    = i_req_valid & r_req_ready;
    assign w_range_err = (i_req_addr >> (P_ADDR_WIDTH + 2)) != 32'd0;
    assign w_err       = w_range_err | lsu_access_err(i_req_we, i_req_f3, i_req_addr[1:0]);

    lsu_lane_align u_lane_align (
        .i_rdata      (i_mem_rdata),
        .i_base       (r_merge),
        .i_wdata      (r_wdata),
        .i_off        (r_off),
        .i_f3         (r_f3),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    // Next-state decode of the access sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_err) begin
                        w_next_state = RESP;
                    end else if (!i_req_we) begin
                        w_next_state = LOAD;
                    end else if (i_req_f3 == F3_W) begin
                        w_next_state = WRITE;
                    end else begin
                        w_next_state = RMW_RD;
                    end
                end else begin
                    w_next_state = IDLE;
                end
            end
            LOAD:   w_next_state = RESP;
            RMW_RD: w_next_state = WRITE;
            WRITE:  w_next_state = RESP;
            RESP: begin
                if (i_rsp_ready) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = RESP;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register and the handshake/strobe outputs derived from the next state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_mem_we    <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_req_ready <= (w_next_state == IDLE);
            r_rsp_valid <= (w_next_state == RESP);
            r_mem_we    <= (w_next_state == WRITE);
        end
    end

    // Request capture, load result and merge buffer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_f3        <= 3'b000;
            r_off       <= 2'b00;
            r_wdata     <= 32'd0;
            r_mem_addr  <= '0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_merge     <= 32'd0;
        end else if (w_accept) begin
            r_f3        <= i_req_f3;
            r_off       <= i_req_addr[1:0];
            r_wdata     <= i_req_wdata;
            r_mem_addr  <= i_req_addr[P_ADDR_WIDTH+1:2];
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= w_err;
        end else if (r_state == LOAD) begin
            r_rsp_rdata <= w_load_data;
        end else if (r_state == RMW_RD) begin
            r_merge     <= i_mem_rdata;
        end else begin
            r_rsp_rdata <= r_rsp_rdata;
        end
    end

    // Write data only leaves the unit while the write strobe is up.
    always_comb begin
        w_mem_wdata = 32'd0;
        if (r_state == WRITE) begin
            if (r_f3 == F3_W) begin
                w_mem_wdata = r_wdata;
            end else begin
                w_mem_wdata = w_merge_data;
            end
        end else begin
            w_mem_wdata = 32'd0;
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_f3    = MEM_F3_WORD;
    assign o_mem_wdata = w_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// traffic against a byte-level reference model of the memory.
module tb_load_store_unit;

    localparam int MEM_WORDS = 2048;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [31:0] i_req_addr;
    logic [2:0]  i_req_f3;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic        o_mem_we;
    logic [10:0] o_mem_addr;
    logic [2:0]  o_mem_f3;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;

    logic [31:0] mem [0:MEM_WORDS-1];
    logic [31:0] ref_mem [0:MEM_WORDS-1];
    logic        bd_we = 1'b0;
    logic [10:0] bd_idx = 11'd0;
    logic [31:0] bd_data = 32'd0;
    int          we_total = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    load_store_unit #(.P_ADDR_WIDTH(11), .P_DATA_WIDTH(32)) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_we    (i_req_we),
        .i_req_addr  (i_req_addr),
        .i_req_f3    (i_req_f3),
        .i_req_wdata (i_req_wdata),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_err   (o_rsp_err),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_f3    (o_mem_f3),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata)
    );

    assign i_mem_rdata = mem[o_mem_addr];

    always @(posedge clk) begin
        if (o_mem_we) begin
            mem[o_mem_addr] <= o_mem_wdata;
            we_total <= we_total + 1;
        end else if (bd_we) begin
            mem[bd_idx] <= bd_data;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic ref_err(input logic we, input logic [31:0] addr, input logic [2:0] f3);
        int size;
        if (addr >= 32'(MEM_WORDS * 4)) return 1'b1;
        if (we && f3 > 3'd2) return 1'b1;
        if (!we && (f3 == 3'd3 || f3 > 3'd5)) return 1'b1;
        size = 1 << f3[1:0];
        return (addr % size) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr, input logic [2:0] f3);
        int    nbytes;
        longint v;
        nbytes = 1 << f3[1:0];
        v = 0;
        for (int i = 0; i < nbytes; i++)
            v = v | (longint'((word >> (8 * (addr % 4 + i))) & 32'hFF) << (8 * i));
        if (f3[2] == 1'b0 && nbytes < 4 && v >= (longint'(1) << (8 * nbytes - 1)))
            v = v - (longint'(1) << (8 * nbytes));
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [31:0] addr,
                                              input logic [2:0] f3, input logic [31:0] wd);
        int          nbytes;
        int          p;
        logic [31:0] w;
        nbytes = 1 << f3[1:0];
        w = word;
        for (int i = 0; i < nbytes; i++) begin
            p = 8 * (addr % 4 + i);
            w = (w & ~(32'hFF << p)) | (((wd >> (8 * i)) & 32'hFF) << p);
        end
        return w;
    endfunction

    function automatic int ref_latency(input logic err, input logic we, input logic [2:0] f3);
        if (err) return 1;
        if (!we || f3 == 3'd2) return 2;
        return 3;
    endfunction

    // ---------------- drivers ----------------
    task automatic set_word(input int idx, input logic [31:0] v);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = idx[10:0]; bd_data = v;
        @(negedge clk);
        bd_we = 1'b0;
        ref_mem[idx] = v;
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wd, input int hold,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output int we_cnt, output int we_cyc, output logic [31:0] we_data,
                          output logic stable, output logic tmo);
        int k;
        lat = 0; rdata = 32'd0; err = 1'b0; we_cnt = 0; we_cyc = 0;
        we_data = 32'd0; stable = 1'b1; tmo = 1'b0;
        i_rsp_ready = (hold == 0);
        @(negedge clk);
        i_req_valid = 1'b1; i_req_we = we; i_req_addr = addr; i_req_f3 = f3; i_req_wdata = wd;
        k = 0;
        while (!o_req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!o_req_ready) begin
            tmo = 1'b1;
            i_req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        i_req_valid = 1'b0;
        k = 1;
        while (!o_rsp_valid && k < 10) begin
            if (o_mem_we) begin
                we_cnt++; we_cyc = k; we_data = o_mem_wdata;
            end
            @(negedge clk);
            k++;
        end
        if (!o_rsp_valid) begin
            tmo = 1'b1;
            i_rsp_ready = 1'b1;
            return;
        end
        if (o_mem_we) we_cnt++;
        lat = k; rdata = o_rsp_rdata; err = o_rsp_err;
        for (int j = 0; j < hold; j++) begin
            @(negedge clk);
            if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== rdata || o_rsp_err !== err || o_req_ready !== 1'b0)
                stable = 1'b0;
            if (o_mem_we) we_cnt++;
        end
        i_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        n_tests++;
        if ({o_req_ready, o_rsp_valid, o_rsp_err, o_mem_we} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000", {o_req_ready, o_rsp_valid, o_rsp_err, o_mem_we});
        end
        n_tests++;
        if (o_rsp_rdata !== 32'd0 || o_mem_addr !== 11'd0 || o_mem_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h expected zeros", o_rsp_rdata, o_mem_addr, o_mem_wdata);
        end
        n_tests++;
        if (o_mem_f3 !== 3'b010) begin
            n_fail++;
            $display("FAIL mem_f3: got %b expected 010", o_mem_f3);
        end
        @(negedge clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (o_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b expected 1", o_req_ready);
        end
    endtask

    task automatic test_lw_basic();
        int lat, wc, wcy; logic [31:0] rd, wdat; logic e, st, tmo;
        set_word(4, 32'h8899AABB);
        do_req(1'b0, 32'h0000_0010, 3'b010, 32'd0, 0, lat, rd, e, wc, wcy, wdat, st, tmo);
        n_tests++;
        if (tmo !== 1'b0 || rd !== 32'h8899AABB || e !== 1'b0 || lat !== 2 || wc !== 0) begin
            n_fail++;
            $display("FAIL lw_basic: tmo=%b rdata=%h err=%b lat=%0d we=%0d expected 0 8899aabb 0 2 0", tmo, rd, e, lat, wc);
        end
    endtask

    task automatic test_lb_lbu();
        int lat, wc, wcy; logic [31:0] rd, wdat; logic e, st, tmo;
        do_req(1'b0, 32'h13, 3'b000, 32'd0, 0, lat, rd, e, wc, wcy, wdat, st, tmo);
        n_tests++;
        if (tmo !== 1'b0 || rd !== 32'hFFFFFF88 || e !== 1'b0 || lat !== 2) begin
            n_fail++;
            $display("FAIL lb_sign: rdata=%h err=%b lat=%0d expected ffffff88 0 2", rd, e, lat);
        end
        do_req(1'b0, 32'h13, 3'b100, 32'd0, 0, lat, rd, e, wc, wcy, wdat, st, tmo);
        n_tests++;
        if (tmo !== 1'b0 || rd !== 32'h00000088 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL lbu_zero: rdata=%h err=%b expected 00000088 0", rd, e);
        end
    endtask

    task automatic test_sb_rmw();
        int lat, wc, wcy; logic [31:0] rd, wdat; logic e, st, tmo;
        set_word(4, 32'h11223344);
        do_req(1'b1, 32'h12, 3'b000, 32'h0000005A, 0, lat, rd, e, wc, wcy, wdat, st, tmo);
        n_tests++;
        if (tmo !== 1'b0 || wc !== 1 || wcy !== 2 || wdat !== 32'h115A3344) begin
            n_fail++;
            $display("FAIL sb_write: tmo=%b we_cnt=%0d we_cyc=%0d wdata=%h expected 0 1 2 115a3344", tmo, wc, wcy, wdat);
        end
        n_tests++;
        if (lat !== 3 || e !== 1'b0 || rd !== 32'd0 || mem[4] !== 32'h115A3344) begin
            n_fail++;
            $display("FAIL sb_resp: lat=%0d err=%b rdata=%h mem=%h expected 3 0 0 115a3344", lat, e, rd, mem[4]);
        end
        ref_mem[4] = 32'h115A3344;
    endtask

    task automatic test_errors();
        int lat, wc, wcy; logic [31:0] rd, wdat; logic e, st, tmo;
        int we_before;
        we_before = we_total;
        do_req(1'b1, 32'h11, 3'b001, 32'h0000BEEF, 0, lat, rd, e, wc, wcy, wdat, st, tmo);
        n_tests++;
        if (tmo !== 1'b0 || e !== 1'b1 || lat !== 1 || wc !== 0) begin
            n_fail++;
            $display("FAIL sh_misaligned: err=%b lat=%0d we=%0d expected 1 1 0", e, lat, wc);
        end
        do_req(1'b0, 32'h0000_2000, 3'b010, 32'd0, 0, lat, rd, e, wc, wcy, wdat, st, tmo);
        n_tests++;
        if (tmo !== 1'b0 || e !== 1'b1 || lat !== 1 || rd !== 32'd0) begin
            n_fail++;
            $display("FAIL lw_range: err=%b lat=%0d rdata=%h expected 1 1 0", e, lat, rd);
        end
        n_tests++;
        if (we_total !== we_before || mem[4] !== ref_mem[4]) begin
            n_fail++;
            $display("FAIL err_no_write: we pulses=%0d mem=%h expected 0 %h", we_total - we_before, mem[4], ref_mem[4]);
        end
    endtask

    task automatic test_backpressure();
        int lat, wc, wcy; logic [31:0] rd, wdat; logic e, st, tmo;
        set_word(5, 32'hCAFEF00D);
        do_req(1'b0, 32'h14, 3'b010, 32'd0, 3, lat, rd, e, wc, wcy, wdat, st, tmo);
        n_tests++;
        if (tmo !== 1'b0 || st !== 1'b1 || rd !== 32'hCAFEF00D || wc !== 0) begin
            n_fail++;
            $display("FAIL backpressure: tmo=%b stable=%b rdata=%h we=%0d expected 0 1 cafef00d 0", tmo, st, rd, wc);
        end
    endtask

    task automatic test_reset_mid_rmw();
        int k; int we_before;
        set_word(4, 32'h11223344);
        @(negedge clk);
        i_rsp_ready = 1'b1;
        i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = 32'h12; i_req_f3 = 3'b000; i_req_wdata = 32'h5A;
        k = 0;
        while (!o_req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        @(negedge clk);
        i_req_valid = 1'b0;
        we_before = we_total;
        i_rst_n = 1'b0;
        #1;
        n_tests++;
        if ({o_req_ready, o_rsp_valid, o_mem_we} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %b expected 000", {o_req_ready, o_rsp_valid, o_mem_we});
        end
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (we_total !== we_before || mem[4] !== 32'h11223344) begin
            n_fail++;
            $display("FAIL reset_mid_write: we pulses=%0d mem=%h expected 0 11223344", we_total - we_before, mem[4]);
        end
        n_tests++;
        if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_recover: ready=%b valid=%b expected 1 0", o_req_ready, o_rsp_valid);
        end
    endtask

    task automatic test_random();
        int lat, wc, wcy; logic [31:0] rd, wdat; logic e, st, tmo;
        logic we; logic [2:0] f3; logic [31:0] addr, wd, exp_rd, exp_w; logic exp_e;
        int idx; int exp_lat;
        for (int n = 0; n < 80; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h0000_2000;
            else addr = 32'($urandom_range(0, 63));
            wd = $urandom;
            idx = int'(addr[12:2]);
            exp_e = ref_err(we, addr, f3);
            exp_lat = ref_latency(exp_e, we, f3);
            exp_rd = (!exp_e && !we) ? ref_load(ref_mem[idx], addr, f3) : 32'd0;
            exp_w = (!exp_e && we) ? ref_store(ref_mem[idx], addr, f3, wd) : 32'd0;
            do_req(we, addr, f3, wd, $urandom_range(0, 2), lat, rd, e, wc, wcy, wdat, st, tmo);
            n_tests++;
            if (tmo !== 1'b0 || e !== exp_e || rd !== exp_rd || lat !== exp_lat || st !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_rsp[%0d]: we=%b f3=%b addr=%h got tmo=%b err=%b rdata=%h lat=%0d stable=%b expected err=%b rdata=%h lat=%0d",
                         n, we, f3, addr, tmo, e, rd, lat, st, exp_e, exp_rd, exp_lat);
            end
            n_tests++;
            if (!exp_e && we) begin
                if (wc !== 1 || wcy !== exp_lat - 1 || wdat !== exp_w || mem[idx] !== exp_w) begin
                    n_fail++;
                    $display("FAIL rand_store[%0d]: we_cnt=%0d we_cyc=%0d wdata=%h mem=%h expected 1 %0d %h",
                             n, wc, wcy, wdat, mem[idx], exp_lat - 1, exp_w);
                end
                ref_mem[idx] = exp_w;
            end else if (wc !== 0) begin
                n_fail++;
                $display("FAIL rand_nowrite[%0d]: we_cnt=%0d expected 0", n, wc);
            end
        end
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_req_valid = 1'b0; i_req_we = 1'b0; i_req_addr = 32'd0;
        i_req_f3 = 3'd0; i_req_wdata = 32'd0; i_rsp_ready = 1'b1;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 32'd0;
        test_reset();
        for (int i = 0; i < 16; i++) set_word(i, $urandom);
        test_lw_basic();
        test_lb_lbu();
        test_sb_rmw();
        test_errors();
        test_backpressure();
        test_reset_mid_rmw();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
